// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word fall-through receive FIFO, with sticky
// overrun / framing-error flags. The line is sampled at mid-bit from a 2-flop synchronized copy.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic                         rx,
  input  logic                         rd_en,
  input  logic                         clr,
  output logic [7:0]                   rd_data,
  output logic                         empty,
  output logic                         full,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         overrun,
  output logic                         frame_err
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned TW = $clog2(CLKS_PER_BIT);

  localparam logic [TW-1:0] TMR_ONE   = TW'(1);
  localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   DEPTH     = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_e;

  logic          rx_meta_q, rxs_q;
  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_req, frame_set;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic          frame_err_q, frame_err_d;
  logic          pop, do_push, overrun_set;

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rx_meta_q <= 1'b1;
      rxs_q     <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rxs_q     <= rx_meta_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_set = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rxs_q) begin
          state_d = START;
          timer_d = '0;
        end
      end
      START: begin
        if (timer_q == HALF_LAST) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = rxs_q ? IDLE : DATA;
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      DATA: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          shift_d = {rxs_q, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      STOP: begin
        if (timer_q == BIT_LAST) begin
          timer_d = '0;
          if (rxs_q) begin
            push_req = 1'b1;
            state_d  = IDLE;
          end else begin
            frame_set = 1'b1;
            state_d   = WAIT_HIGH;
          end
        end else begin
          timer_d = timer_q + TMR_ONE;
        end
      end
      WAIT_HIGH: begin
        if (rxs_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A push into a full FIFO is only accepted when the same cycle frees a slot.
  assign pop         = rd_en && !empty;
  assign do_push     = push_req && (!full || pop);
  assign overrun_set = push_req && full && !pop;

  always_comb begin
    wr_ptr_d    = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d     = count_q;
    if (do_push && !pop) count_d = count_q + CNT_ONE;
    else if (pop && !do_push) count_d = count_q - CNT_ONE;
    // Set events take priority over a same-cycle clear.
    overrun_d   = overrun_set ? 1'b1 : (clr ? 1'b0 : overrun_q);
    frame_err_d = frame_set ? 1'b1 : (clr ? 1'b0 : frame_err_q);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define
  // which entries are valid, and rd_data is gated below so reset still shows 0.
  always_ff @(posedge HCLK) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == DEPTH);
  assign count     = count_q;
  assign rd_data   = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frames are bit-banged on rx from the falling
// clock edge; outputs are sampled on falling edges with hand-computed expectations.
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 8;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic       rx;
  logic       rd_en;
  logic       clr;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [3:0] count;
  logic       overrun;
  logic       frame_err;

  int n_checks = 0;
  int n_fail   = 0;

  uart_rx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .rx       (rx),
    .rd_en    (rd_en),
    .clr      (clr),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .count    (count),
    .overrun  (overrun),
    .frame_err(frame_err)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  // Hold rx at b for n clock cycles; always entered and left on a falling edge.
  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(negedge HCLK);
  endtask

  // The stop sample lands on the 11th rising edge into the stop bit, so rd_en is
  // raised just around that edge when requested.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic rd_at_push);
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(data[i], CPB);
    drive_bit(stop_bit, 10);
    rd_en = rd_at_push;
    drive_bit(stop_bit, 1);
    rd_en = 1'b0;
    drive_bit(stop_bit, 5);
  endtask

  task automatic do_pop();
    rd_en = 1'b1;
    @(negedge HCLK);
    rd_en = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    @(negedge HCLK);
    clr = 1'b0;
  endtask

  task automatic test_reset();
    HRESETn = 1'b0;
    rx      = 1'b1;
    rd_en   = 1'b0;
    clr     = 1'b0;
    repeat (3) @(negedge HCLK);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b expected 1", empty); end
    n_checks++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b expected 0", full); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d expected 0", count); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
    HRESETn = 1'b1;
    drive_bit(1'b1, 8);
  endtask

  task automatic test_basic();
    logic [7:0] d;
    d = 8'h41;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    drive_bit(1'b1, 10);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL basic_before_push: count got %0d expected 0", count); end
    drive_bit(1'b1, 1);
    n_checks++; if (empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty: got %b expected 0", empty); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL basic_count: got %0d expected 1", count); end
    n_checks++; if (rd_data !== 8'h41) begin n_fail++; $display("FAIL basic_rd_data: got %h expected 41", rd_data); end
    drive_bit(1'b1, 5);
    do_pop();
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL basic_pop_empty: got %b expected 1", empty); end
  endtask

  task automatic test_glitch();
    drive_bit(1'b0, 3);
    drive_bit(1'b1, 40);
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL glitch_count: got %0d expected 0", count); end
    n_checks++; if ({overrun, frame_err} !== 2'b00) begin n_fail++; $display("FAIL glitch_flags: got %b expected 00", {overrun, frame_err}); end
    send_frame(8'h3A, 1'b1, 1'b0);
    n_checks++; if (rd_data !== 8'h3A) begin n_fail++; $display("FAIL glitch_next_byte: got %h expected 3a", rd_data); end
    do_pop();
  endtask

  task automatic test_frame_err();
    send_frame(8'h55, 1'b0, 1'b0);
    drive_bit(1'b0, 40);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_set: got %b expected 1", frame_err); end
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL ferr_no_push: count got %0d expected 0", count); end
    drive_bit(1'b1, 16);
    send_frame(8'h0F, 1'b1, 1'b0);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_sticky: got %b expected 1", frame_err); end
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL ferr_count: got %0d expected 1", count); end
    n_checks++; if (rd_data !== 8'h0F) begin n_fail++; $display("FAIL ferr_rd_data: got %h expected 0f", rd_data); end
    do_pop();
    pulse_clr();
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL ferr_clr: got %b expected 0", frame_err); end
  endtask

  task automatic test_clr_priority();
    logic [7:0] d;
    d = 8'hC3;
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive_bit(d[i], CPB);
    clr = 1'b1;
    drive_bit(1'b0, 11);
    n_checks++; if (frame_err !== 1'b1) begin n_fail++; $display("FAIL clr_prio_set_wins: got %b expected 1", frame_err); end
    drive_bit(1'b0, 1);
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL clr_prio_then_clear: got %b expected 0", frame_err); end
    clr = 1'b0;
    drive_bit(1'b0, 4);
    drive_bit(1'b1, 16);
  endtask

  task automatic test_overrun();
    logic [7:0] exp;
    for (int i = 0; i < 9; i++) send_frame(8'(i), 1'b1, 1'b0);
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL ovr_count: got %0d expected 8", count); end
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL ovr_full: got %b expected 1", full); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
    for (int i = 0; i < 8; i++) begin
      exp = 8'(i);
      n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL ovr_drain[%0d]: got %h expected %h", i, rd_data, exp); end
      do_pop();
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovr_drained_empty: got %b expected 1", empty); end
    do_pop();
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL pop_on_empty_count: got %0d expected 0", count); end
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b expected 1", overrun); end
    pulse_clr();
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clr: got %b expected 0", overrun); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp;
    for (int i = 0; i < 8; i++) send_frame(8'h10 + 8'(i), 1'b1, 1'b0);
    n_checks++; if (full !== 1'b1) begin n_fail++; $display("FAIL fpp_full: got %b expected 1", full); end
    send_frame(8'hA5, 1'b1, 1'b1);
    n_checks++; if (count !== 4'd8) begin n_fail++; $display("FAIL fpp_count: got %0d expected 8", count); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fpp_overrun: got %b expected 0", overrun); end
    for (int i = 0; i < 8; i++) begin
      exp = (i == 7) ? 8'hA5 : 8'h11 + 8'(i);
      n_checks++; if (rd_data !== exp) begin n_fail++; $display("FAIL fpp_drain[%0d]: got %h expected %h", i, rd_data, exp); end
      do_pop();
    end
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty: got %b expected 1", empty); end
  endtask

  task automatic test_push_pop_empty();
    send_frame(8'h5A, 1'b1, 1'b1);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL ppe_count: got %0d expected 1", count); end
    n_checks++; if (rd_data !== 8'h5A) begin n_fail++; $display("FAIL ppe_rd_data: got %h expected 5a", rd_data); end
    do_pop();
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0] d;
    d = 8'h3C;
    send_frame(8'h77, 1'b1, 1'b0);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL rmf_pre_count: got %0d expected 1", count); end
    drive_bit(1'b0, CPB);
    for (int i = 0; i < 4; i++) drive_bit(d[i], CPB);
    drive_bit(d[4], 8);
    HRESETn = 1'b0;
    #1;
    n_checks++; if (count !== 4'd0) begin n_fail++; $display("FAIL rmf_async_count: got %0d expected 0", count); end
    n_checks++; if (rd_data !== 8'h00) begin n_fail++; $display("FAIL rmf_async_rd_data: got %h expected 00", rd_data); end
    rx = 1'b1;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    drive_bit(1'b1, 32);
    n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rmf_no_partial: empty got %b expected 1", empty); end
    send_frame(8'h99, 1'b1, 1'b0);
    n_checks++; if (count !== 4'd1) begin n_fail++; $display("FAIL rmf_count: got %0d expected 1", count); end
    n_checks++; if (rd_data !== 8'h99) begin n_fail++; $display("FAIL rmf_rd_data: got %h expected 99", rd_data); end
    n_checks++; if ({overrun, frame_err} !== 2'b00) begin n_fail++; $display("FAIL rmf_flags: got %b expected 00", {overrun, frame_err}); end
    do_pop();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_clr_priority();
    test_overrun();
    test_full_push_pop();
    test_push_pop_empty();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, meaning HCLK cycles per UART bit (min 4, even).
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, meaning receive FIFO entries (power of 2, 2..64).
REQ-003 SHALL have port HCLK  input  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port HRESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port rx  input  1  serial line, idle high, 8N1, LSB first.
REQ-006 SHALL have port rd_en  input  1  pop head entry this cycle.
REQ-007 SHALL have port clr  input  1  clear sticky error flags this cycle.
REQ-008 SHALL have port rd_data  output  8  FIFO head, first-word fall-through.
REQ-009 SHALL have port empty  output  1  FIFO holds 0 entries.
REQ-010 SHALL have port full  output  1  FIFO holds FIFO_DEPTH entries.
REQ-011 SHALL have port count  output  log2(FIFO_DEPTH)+1  entries held.
REQ-012 SHALL have port overrun  output  1  sticky: byte dropped because FIFO was full.
REQ-013 SHALL have port frame_err  output  1  sticky: stop bit sampled low.

Function
REQ-014 SHALL pass rx through a 2-flop synchronizer (reset value 1); all line decisions use the synchronized value rxs.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-016 IDLE: rxs==0 -> START, bit timer cleared.
REQ-017 START: after CLKS_PER_BIT/2 cycles, sample rxs; 0 -> DATA, 1 -> IDLE (glitch rejected, nothing recorded).
REQ-018 DATA: sample rxs every CLKS_PER_BIT cycles into shift register LSB first; after bit 7 -> STOP.
REQ-019 STOP: after CLKS_PER_BIT cycles sample rxs; 1 -> push byte, -> IDLE; 0 -> set frame_err, no push, -> WAIT_HIGH.
REQ-020 WAIT_HIGH: stay until rxs==1, then -> IDLE.
REQ-021 Push SHALL occur on the stop-sample edge; empty/count/rd_data reflect it the following cycle.
REQ-022 rd_data SHALL equal the oldest entry whenever empty==0; value undefined-but-stable when empty==1.
REQ-023 rd_en with empty==1 SHALL be ignored (no pointer or count change).
REQ-024 Push with full==1 and no rd_en SHALL drop the byte and set overrun; FIFO contents unchanged.
REQ-025 Push and rd_en in same cycle with full==1 SHALL pop and push, count unchanged, overrun unchanged.
REQ-026 Push and rd_en in same cycle with empty==1 SHALL push only; count becomes 1.
REQ-027 Pointers SHALL wrap modulo FIFO_DEPTH; count SHALL never exceed FIFO_DEPTH or underflow.
REQ-028 clr SHALL zero overrun and frame_err next cycle; a same-cycle set event SHALL win over clr.
REQ-029 Line timing SHALL tolerate ±3% baud mismatch for a 10-bit frame.

Reset
REQ-030 HRESETn low SHALL immediately force: FSM IDLE, sync flops 1, timers 0, pointers 0, count 0, empty 1, full 0, overrun 0, frame_err 0, rd_data 0.
REQ-031 Reset mid-frame SHALL discard the partial byte; after release, reception resumes only at the next falling edge seen in IDLE.

Verification
REQ-032 Send 0x41 at 16 clk/bit -> one cycle after stop sample: empty=0, count=1, rd_data=0x41; rd_en one cycle -> empty=1.
REQ-033 Drive rx low 3 cycles then high -> FSM returns to IDLE, count=0, no flags.
REQ-034 Send 0x55 with stop bit 0, hold rx low 40 cycles, then send 0x0F -> frame_err=1, count=1, rd_data=0x0F.
REQ-035 Send 0x00..0x08 with no reads -> count=8, full=1, overrun=1, popping yields 0x00..0x07; clr -> overrun=0.
REQ-036 With FIFO full, assert rd_en on the push cycle of 0xA5 -> count stays 8, overrun=0, last entry 0xA5.
REQ-037 Assert HRESETn low during DATA bit 4 of 0x3C, release, send 0x99 -> count=1, rd_data=0x99, no flags.
